// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one square-root unit between N stb/ack requesters.
// One operation is in flight at a time; each result returns to the port that issued it.
module sqrt_arbiter #(
  parameter int N  = 4,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*32-1:0] req_a,
  input  logic [N-1:0]    req_a_stb,
  output logic [N-1:0]    req_a_ack,
  output logic [31:0]     rsp_z,
  output logic [N-1:0]    rsp_z_stb,
  input  logic [N-1:0]    rsp_z_ack,
  output logic [31:0]     unit_a,
  output logic            unit_a_stb,
  input  logic            unit_a_ack,
  input  logic [31:0]     unit_z,
  input  logic            unit_z_stb,
  output logic            unit_z_ack,
  output logic            busy,
  output logic [2:0]      grant_id,
  output logic [CW-1:0]   done_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ISSUE,
    S_WAIT,
    S_RETURN
  } state_e;

  localparam logic [N-1:0] ONE = N'(1);

  state_e        state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [2:0]    grant_q, grant_d;
  logic [31:0]   op_q, op_d;
  logic [31:0]   res_q, res_d;
  logic [N-1:0]  req_ack_q, req_ack_d;
  logic [N-1:0]  rsp_stb_q, rsp_stb_d;
  logic          unit_stb_q, unit_stb_d;
  logic          zack_q, zack_d;
  logic [CW-1:0] done_q, done_d;

  logic [2:0]    pick;
  logic          any_req;
  logic [2:0]    idx;
  logic [N-1:0]  stb_sh;
  logic [31:0]   op_sel;

  // (base + off) mod N for base < N and off <= N.
  function automatic logic [2:0] wrap_add(input logic [2:0] base, input int off);
    logic [3:0] s;
    s = {1'b0, base} + 4'(off);
    if (s >= 4'(N)) s = s - 4'(N);
    return s[2:0];
  endfunction

  // Walk offsets from farthest to nearest so the first asserted port after ptr wins.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    pick    = ptr_q;
    any_req = 1'b0;
    idx     = ptr_q;
    stb_sh  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx    = wrap_add(ptr_q, k);
      stb_sh = req_a_stb >> idx;
      if (stb_sh[0]) begin
        pick    = idx;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    op_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q == 3'(i)) op_sel = req_a[i*32 +: 32];
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    op_d       = op_q;
    res_d      = res_q;
    req_ack_d  = req_ack_q;
    rsp_stb_d  = rsp_stb_q;
    unit_stb_d = unit_stb_q;
    zack_d     = zack_q;
    done_d     = done_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_d   = pick;
          req_ack_d = ONE << pick;
          state_d   = S_GRANT;
        end
      end
      S_GRANT: begin
        // A withdrawn stb simply holds here with ack still high.
        if (|(req_a_stb & req_ack_q)) begin
          op_d       = op_sel;
          req_ack_d  = '0;
          unit_stb_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (unit_stb_q && unit_a_ack) begin
          unit_stb_d = 1'b0;
          zack_d     = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (zack_q && unit_z_stb) begin
          res_d     = unit_z;
          zack_d    = 1'b0;
          rsp_stb_d = ONE << grant_q;
          state_d   = S_RETURN;
        end
      end
      S_RETURN: begin
        if (|(rsp_z_ack & rsp_stb_q)) begin
          rsp_stb_d = '0;
          ptr_d     = wrap_add(grant_q, 1);
          done_d    = done_q + CW'(1);
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: op and res are plain registers, not a memory, so they reset with the control state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      op_q       <= '0;
      res_q      <= '0;
      req_ack_q  <= '0;
      rsp_stb_q  <= '0;
      unit_stb_q <= 1'b0;
      zack_q     <= 1'b0;
      done_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      op_q       <= op_d;
      res_q      <= res_d;
      req_ack_q  <= req_ack_d;
      rsp_stb_q  <= rsp_stb_d;
      unit_stb_q <= unit_stb_d;
      zack_q     <= zack_d;
      done_q     <= done_d;
    end
  end

  assign req_a_ack  = req_ack_q;
  assign rsp_z      = res_q;
  assign rsp_z_stb  = rsp_stb_q;
  assign unit_a     = op_q;
  assign unit_a_stb = unit_stb_q;
  assign unit_z_ack = zack_q;
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = grant_q;
  assign done_count = done_q;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter: requester/unit environment plus one task per scenario.
module tb_sqrt_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] req_a;
  logic [3:0]   req_a_stb;
  logic [3:0]   req_a_ack;
  logic [31:0]  rsp_z;
  logic [3:0]   rsp_z_stb;
  logic [3:0]   rsp_z_ack;
  logic [31:0]  unit_a;
  logic         unit_a_stb;
  logic         unit_a_ack;
  logic [31:0]  unit_z;
  logic         unit_z_stb;
  logic         unit_z_ack;
  logic         busy;
  logic [2:0]   grant_id;
  logic [3:0]   done_count;

  sqrt_arbiter #(.N(4), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_a_stb(req_a_stb), .req_a_ack(req_a_ack),
    .rsp_z(rsp_z), .rsp_z_stb(rsp_z_stb), .rsp_z_ack(rsp_z_ack),
    .unit_a(unit_a), .unit_a_stb(unit_a_stb), .unit_a_ack(unit_a_ack),
    .unit_z(unit_z), .unit_z_stb(unit_z_stb), .unit_z_ack(unit_z_ack),
    .busy(busy), .grant_id(grant_id), .done_count(done_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] rq [4][$];
  int          tx_log [$];
  int          res_port [$];
  logic [31:0] res_val [$];
  logic [3:0]  res_stb [$];
  int          ack_cnt [4];
  int          zack_cnt;
  logic [3:0]  rsp_en;
  int          lat;

  logic [3:0]  p_rstb, p_rack, p_zstb, p_zack;
  logic [31:0] p_rspz, p_ua;
  logic        p_ustb, p_uack, p_uzs, p_uza;
  logic        u_pend;
  int          u_cnt;
  logic [31:0] u_op;

  // Square roots of the operands used below, worked out by hand.
  function automatic logic [31:0] unit_fn(input logic [31:0] a);
    case (a)
      32'h3F800000: return 32'h3F800000;
      32'h40100000: return 32'h3FC00000;
      32'h40800000: return 32'h40000000;
      32'h41100000: return 32'h40400000;
      32'h41800000: return 32'h40800000;
      32'h41C80000: return 32'h40A00000;
      32'h42100000: return 32'h40C00000;
      32'h42C80000: return 32'h41200000;
      default:      return 32'hDEADBEEF;
    endcase
  endfunction

  // Requesters and unit model; everything is sampled and driven 1 time unit after posedge.
  initial begin
    req_a = '0; req_a_stb = '0; rsp_z_ack = '0;
    unit_a_ack = 1'b0; unit_z_stb = 1'b0; unit_z = '0;
    u_pend = 1'b0; u_cnt = 0; u_op = '0; zack_cnt = 0;
    p_rstb = '0; p_rack = '0; p_zstb = '0; p_zack = '0; p_rspz = '0;
    p_ua = '0; p_ustb = 1'b0; p_uack = 1'b0; p_uzs = 1'b0; p_uza = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        req_a_stb = '0; req_a = '0;
        unit_a_ack = 1'b0; unit_z_stb = 1'b0; unit_z = '0; u_pend = 1'b0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (req_a_ack[i]) ack_cnt[i]++;
          if (p_rstb[i] && p_rack[i]) begin
            tx_log.push_back(i);
            rq[i].delete(0);
            if (rq[i].size() > 0) req_a[i*32 +: 32] = rq[i][0];
            else req_a_stb[i] = 1'b0;
          end else if (!req_a_stb[i] && rq[i].size() > 0) begin
            req_a_stb[i] = 1'b1;
            req_a[i*32 +: 32] = rq[i][0];
          end
          if (p_zstb[i] && p_zack[i]) begin
            res_port.push_back(i);
            res_val.push_back(p_rspz);
            res_stb.push_back(p_zstb);
          end
        end
        rsp_z_ack = rsp_en;
        if (unit_z_ack) zack_cnt++;
        if (p_ustb && p_uack) begin
          unit_a_ack = 1'b0; u_op = p_ua; u_cnt = lat; u_pend = 1'b1;
        end else if (unit_a_stb && !unit_a_ack && !u_pend && !unit_z_stb) begin
          unit_a_ack = 1'b1;
        end
        if (p_uzs && p_uza) unit_z_stb = 1'b0;
        if (u_pend) begin
          if (u_cnt == 0) begin
            unit_z = unit_fn(u_op); unit_z_stb = 1'b1; u_pend = 1'b0;
          end else begin
            u_cnt--;
          end
        end
      end
      p_rstb = req_a_stb; p_rack = req_a_ack; p_zstb = rsp_z_stb; p_zack = rsp_z_ack;
      p_rspz = rsp_z; p_ua = unit_a; p_ustb = unit_a_stb; p_uack = unit_a_ack;
      p_uzs = unit_z_stb; p_uza = unit_z_ack;
    end
  end

  task automatic clear_env();
    for (int i = 0; i < 4; i++) begin
      rq[i].delete();
      ack_cnt[i] = 0;
    end
    tx_log.delete(); res_port.delete(); res_val.delete(); res_stb.delete();
    zack_cnt = 0; rsp_en = 4'hF; lat = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_env();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic wait_results(input int n, input int max_cyc, input string name);
    for (int c = 0; c < max_cyc && res_port.size() < n; c++) begin
      @(posedge clk); #2;
    end
    total++;
    if (res_port.size() < n) begin
      bad++;
      $display("FAIL %s timeout: results=%0d required=%0d", name, res_port.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_env();
    #12;
    total++;
    if ({busy, req_a_ack, rsp_z_stb, unit_a_stb, unit_z_ack} !== 11'd0) begin
      bad++; $display("FAIL reset_ctrl got=%b required=0", {busy, req_a_ack, rsp_z_stb, unit_a_stb, unit_z_ack});
    end
    total++;
    if ({unit_a, rsp_z, grant_id, done_count} !== 71'd0) begin
      bad++; $display("FAIL reset_data unit_a=%h rsp_z=%h grant=%0d done=%0d required all 0",
                      unit_a, rsp_z, grant_id, done_count);
    end
    do_reset();
    total++;
    if (busy !== 1'b0 || req_a_ack !== 4'd0) begin
      bad++; $display("FAIL reset_idle busy=%b ack=%b required 0/0000", busy, req_a_ack);
    end
  endtask

  task automatic test_single();
    do_reset();
    rq[0].push_back(32'h40800000);
    wait_results(1, 60, "single");
    if (res_port.size() >= 1) begin
      total++;
      if (res_port[0] != 0 || res_val[0] !== 32'h40000000) begin
        bad++; $display("FAIL single_result port=%0d val=%h required port=0 val=40000000", res_port[0], res_val[0]);
      end
      total++;
      if (res_stb[0] !== 4'b0001) begin
        bad++; $display("FAIL single_stb got=%b required=0001", res_stb[0]);
      end
    end
    total++;
    if (done_count !== 4'd1) begin
      bad++; $display("FAIL single_done got=%0d required=1", done_count);
    end
    total++;
    if (ack_cnt[0] != 1 || ack_cnt[1] + ack_cnt[2] + ack_cnt[3] != 0) begin
      bad++; $display("FAIL single_acks got=%0d,%0d,%0d,%0d required=1,0,0,0",
                      ack_cnt[0], ack_cnt[1], ack_cnt[2], ack_cnt[3]);
    end
    total++;
    if (zack_cnt != 1) begin
      bad++; $display("FAIL single_unit_ack_len got=%0d required=1", zack_cnt);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] ops [4];
    logic [31:0] exp [4];
    ops = '{32'h41100000, 32'h41800000, 32'h41C80000, 32'h42100000};
    exp = '{32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    do_reset();
    for (int i = 0; i < 4; i++) rq[i].push_back(ops[i]);
    wait_results(4, 120, "simultaneous");
    for (int k = 0; k < 4 && k < res_port.size(); k++) begin
      total++;
      if (res_port[k] != k || res_val[k] !== exp[k]) begin
        bad++; $display("FAIL simul_result%0d port=%0d val=%h required port=%0d val=%h",
                        k, res_port[k], res_val[k], k, exp[k]);
      end
    end
    total++;
    if (done_count !== 4'd4) begin
      bad++; $display("FAIL simul_done got=%0d required=4", done_count);
    end
  endtask

  task automatic test_fairness();
    logic [31:0] ops0 [4];
    logic [31:0] ops2 [4];
    logic [31:0] exp0 [4];
    logic [31:0] exp2 [4];
    int          ep;
    logic [31:0] ev;
    ops0 = '{32'h40800000, 32'h41800000, 32'h42100000, 32'h42C80000};
    exp0 = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41200000};
    ops2 = '{32'h41100000, 32'h41C80000, 32'h3F800000, 32'h40100000};
    exp2 = '{32'h40400000, 32'h40A00000, 32'h3F800000, 32'h3FC00000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rq[0].push_back(ops0[i]);
      rq[2].push_back(ops2[i]);
    end
    wait_results(8, 200, "fairness");
    for (int k = 0; k < 8 && k < res_port.size(); k++) begin
      ep = (k % 2 == 0) ? 0 : 2;
      ev = (k % 2 == 0) ? exp0[k/2] : exp2[k/2];
      total++;
      if (res_port[k] != ep || res_val[k] !== ev) begin
        bad++; $display("FAIL fair_result%0d port=%0d val=%h required port=%0d val=%h",
                        k, res_port[k], res_val[k], ep, ev);
      end
    end
    total++;
    if (ack_cnt[1] + ack_cnt[3] != 0) begin
      bad++; $display("FAIL fair_idle_ports acks1=%0d acks3=%0d required 0", ack_cnt[1], ack_cnt[3]);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int          viol;
    do_reset();
    rsp_en = 4'b1101;
    rq[1].push_back(32'h41100000);
    for (int c = 0; c < 60 && rsp_z_stb !== 4'b0010; c++) begin
      @(posedge clk); #2;
    end
    total++;
    if (rsp_z_stb !== 4'b0010 || rsp_z !== 32'h40400000) begin
      bad++; $display("FAIL bp_first stb=%b rsp_z=%h required 0010/40400000", rsp_z_stb, rsp_z);
    end
    rq[3].push_back(32'h41800000);
    held = rsp_z;
    viol = 0;
    repeat (10) begin
      @(posedge clk); #2;
      if (rsp_z_stb !== 4'b0010 || rsp_z !== held || req_a_ack !== 4'd0 || grant_id !== 3'd1) viol++;
    end
    total++;
    if (viol != 0) begin
      bad++; $display("FAIL bp_stall unstable_cycles=%0d required=0", viol);
    end
    rsp_en = 4'hF;
    wait_results(2, 80, "bp_drain");
    if (res_port.size() >= 2) begin
      total++;
      if (res_port[0] != 1 || res_port[1] != 3 || res_val[1] !== 32'h40800000) begin
        bad++; $display("FAIL bp_order ports=%0d,%0d val=%h required 1,3 val=40800000",
                        res_port[0], res_port[1], res_val[1]);
      end
    end
    total++;
    if (ack_cnt[3] != 1) begin
      bad++; $display("FAIL bp_port3_ack got=%0d required=1", ack_cnt[3]);
    end
  endtask

  task automatic test_reset_wait();
    do_reset();
    lat = 30;
    rq[1].push_back(32'h40800000);
    for (int c = 0; c < 60 && unit_z_ack !== 1'b1; c++) begin
      @(posedge clk); #2;
    end
    total++;
    if (unit_z_ack !== 1'b1 || busy !== 1'b1 || grant_id !== 3'd1) begin
      bad++; $display("FAIL rw_inwait zack=%b busy=%b grant=%0d required 1/1/1", unit_z_ack, busy, grant_id);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({busy, req_a_ack, rsp_z_stb, unit_a_stb, unit_z_ack} !== 11'd0) begin
      bad++; $display("FAIL rw_ctrl got=%b required=0", {busy, req_a_ack, rsp_z_stb, unit_a_stb, unit_z_ack});
    end
    total++;
    if ({unit_a, rsp_z, grant_id, done_count} !== 71'd0) begin
      bad++; $display("FAIL rw_data unit_a=%h rsp_z=%h grant=%0d done=%0d required all 0",
                      unit_a, rsp_z, grant_id, done_count);
    end
    clear_env();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #2;
    rq[2].push_back(32'h3F800000);
    wait_results(1, 60, "rw_fresh");
    if (res_port.size() >= 1) begin
      total++;
      if (res_port[0] != 2 || res_val[0] !== 32'h3F800000) begin
        bad++; $display("FAIL rw_fresh_result port=%0d val=%h required port=2 val=3F800000", res_port[0], res_val[0]);
      end
    end
    total++;
    if (done_count !== 4'd1) begin
      bad++; $display("FAIL rw_done got=%0d required=1", done_count);
    end
  endtask

  task automatic test_wrap();
    int wrong;
    do_reset();
    for (int i = 0; i < 17; i++) rq[1].push_back(32'h40800000);
    wait_results(16, 400, "wrap16");
    total++;
    if (done_count !== 4'd0) begin
      bad++; $display("FAIL wrap_at16 got=%0d required=0", done_count);
    end
    wait_results(17, 60, "wrap17");
    total++;
    if (done_count !== 4'd1) begin
      bad++; $display("FAIL wrap_at17 got=%0d required=1", done_count);
    end
    wrong = 0;
    foreach (res_val[k]) if (res_val[k] !== 32'h40000000 || res_port[k] != 1) wrong++;
    total++;
    if (wrong != 0) begin
      bad++; $display("FAIL wrap_results wrong=%0d required=0", wrong);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_reset_wait();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sqrt_arbiter.md
# sqrt_arbiter

Round-robin arbiter that shares one single-precision square-root unit (32-bit stb/ack operand and result channels) between N requesters. Each requester has its own operand channel and result channel. The arbiter serialises requests and issues one operation at a time to the unit. It routes each result back to the requester that issued the operand. It sits between the client datapaths and the `sqrt` instance, and all of its handshakes follow the codebase stb/ack protocol.

## Interface
- N, 4, number of requesters (2..8)
- CW, 16, width of the completed-operation counter
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  one clock; reset is asynchronous and active-low
- req_a  in  N*32  requester operands; port i occupies bits [32i+31:32i]
- req_a_stb  in  N  operand valid, one per requester
- req_a_ack  out  N  operand accepted, one per requester
- rsp_z  out  32  result, shared by all requesters
- rsp_z_stb  out  N  result valid; one-hot or zero
- rsp_z_ack  in  N  result taken, one per requester
- unit_a  out  32  operand to sqrt unit
- unit_a_stb  out  1  operand valid to unit
- unit_a_ack  in  1  unit accepted operand
- unit_z  in  32  result from unit
- unit_z_stb  in  1  unit result valid
- unit_z_ack  out  1  result taken from unit
- busy  out  1  high in every state except IDLE
- grant_id  out  3  index of the current or last granted requester
- done_count  out  CW  completed operations; wraps modulo 2^CW

## Operation
- Transfer rule: a transfer occurs on a rising edge where stb and ack are both high. Every stb and ack output is a register.
- States are IDLE, GRANT, ISSUE, WAIT, RETURN. Exactly one operation is in flight at a time.
- IDLE: if any req_a_stb is high, select g = the first asserted index searching ptr, ptr+1, … mod N. Register grant_id<=g and req_a_ack[g]<=1, then go to GRANT.
- GRANT: on transfer on port g, register op<=req_a[g] and req_a_ack[g]<=0, set unit_a_stb<=1, then go to ISSUE.
  - If req_a_stb[g] drops before transfer, the block holds GRANT with ack high. Requesters must not withdraw.
- ISSUE: unit_a=op. On transfer, set unit_a_stb<=0 and unit_z_ack<=1, then go to WAIT.
- WAIT: on transfer, register res<=unit_z, set unit_z_ack<=0 and rsp_z_stb[g]<=1, then go to RETURN. There is no timeout; WAIT holds indefinitely.
- RETURN: rsp_z=res. On transfer on port g:
  - set rsp_z_stb[g]<=0;
  - set ptr<=(g+1) mod N;
  - increment done_count;
  - go to IDLE.
- Results pass through bit-exact. NaN, inf and negative inputs are handled by the unit, not the arbiter.
- rsp_z_ack on non-granted ports and req_a_stb on non-granted ports have no effect until those ports are granted.
- Reset (rst low, asynchronous), whatever the current state:
  - state=IDLE, ptr=0, grant_id=0, done_count=0;
  - all stb/ack outputs 0;
  - op, res, unit_a, rsp_z = 0.
  - An in-flight operation is discarded. The unit must be reset in the same window.

## Timing
- From req_a_stb high in IDLE, req_a_ack[g] is high 1 cycle later.
- unit_a_stb rises on the edge of the requester transfer.
- unit_z_ack rises on the edge of the operand transfer to the unit.
- rsp_z_stb[g] rises on the edge of the unit-result transfer.
- Arbiter overhead per operation, with zero-wait requester and unit: 4 cycles plus the unit latency plus 1 cycle of IDLE re-arbitration.
- A new grant is never issued before rsp_z transfers. Back-pressure on rsp_z_ack stalls the whole block.
- The ack pulses toward requesters and toward the unit are exactly one cycle long when the counterpart stb is already high.
- done_count increments on the RETURN transfer edge. It is visible the next cycle and wraps from 2^CW-1 to 0.

## Test plan
- Single operation: port 0 sends 0x40800000 (4.0) → rsp_z=0x40000000 with rsp_z_stb=0001; done_count=1; no other port is acked.
- Simultaneous requests: all four ports request in the same cycle with 0x41100000, 0x41800000, 0x41C80000, 0x42100000 → results 0x40400000, 0x40800000, 0x40A00000, 0x40C00000 return in port order 0,1,2,3.
- Fairness: ports 0 and 2 re-request continuously → grants alternate 0,2,0,2 over 8 operations; ports 1 and 3 are never acked.
- Response back-pressure: hold rsp_z_ack[1] low for 10 cycles → rsp_z_stb[1] and rsp_z stay stable; the pending port-3 request is not acked until after the port-1 transfer.
- Reset mid-WAIT: pull rst low with the unit busy → all outputs are 0 immediately (asynchronous); after release, a fresh port-2 request for 0x3F800000 returns 0x3F800000.
- Counter wrap: with CW=4, run 17 operations → done_count reads 1.
